// File: rtl/ahb_arbiter.sv
// Two-manager AHB bus arbiter with registered grant, address/data-phase muxing and burst hold.
// Define AHB_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed priority (M0 first).
module ahb_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [1:0]            HBUSREQ,
  input  logic [1:0]            HLOCK,
  input  logic [ADDR_WIDTH-1:0] HADDR_M0,
  input  logic [ADDR_WIDTH-1:0] HADDR_M1,
  input  logic [1:0]            HTRANS_M0,
  input  logic [1:0]            HTRANS_M1,
  input  logic                  HWRITE_M0,
  input  logic                  HWRITE_M1,
  input  logic [2:0]            HSIZE_M0,
  input  logic [2:0]            HSIZE_M1,
  input  logic [2:0]            HBURST_M0,
  input  logic [2:0]            HBURST_M1,
  input  logic [DATA_WIDTH-1:0] HWDATA_M0,
  input  logic [DATA_WIDTH-1:0] HWDATA_M1,
  input  logic                  HREADY,
  input  logic [1:0]            HRESP,
  output logic [1:0]            HGRANT,
  output logic                  HMASTER,
  output logic                  HMASTLOCK,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [DATA_WIDTH-1:0] HWDATA
);

  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [1:0] RESP_ERROR   = 2'b01;

  logic [1:0] grant_q, grant_d;
  logic       master_q, master_d;
  logic       owner_q, owner_d;
  logic       mastlock_q, mastlock_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic       gidx_s;
  logic       hold_s;
  logic       win_s;

  assign gidx_s = grant_q[1];

  // Arbitration: pick a winner, hold it for locks and unfinished fixed-length bursts.
  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    win_s   = 1'b0;
    hold_s  = HLOCK[gidx_s] | ((cnt_q > 4'd1) & (HRESP != RESP_ERROR));
    case (HBUSREQ)
      2'b00:   win_s = 1'b0;
      2'b01:   win_s = 1'b0;
      2'b10:   win_s = 1'b1;
`ifdef AHB_ARB_ROUND_ROBIN_EN
      2'b11:   win_s = ~last_q;
`else
      2'b11:   win_s = 1'b0;
`endif
      default: win_s = 1'b0;
    endcase
    if (HREADY && !hold_s) begin
      grant_d = win_s ? 2'b10 : 2'b01;
      if (grant_d != grant_q) begin
        last_d = win_s;
      end else begin
        last_d = last_q;
      end
    end else begin
      grant_d = grant_q;
    end
  end

  // Beat counter tracks remaining beats of the accepted fixed-length burst; ERROR aborts it.
  always_comb begin
    cnt_d = cnt_q;
    if (HRESP == RESP_ERROR) begin
      cnt_d = 4'd0;
    end else if (HREADY) begin
      case (HTRANS)
        TRANS_NONSEQ: begin
          case (HBURST)
            3'b010, 3'b011: cnt_d = 4'd3;
            3'b100, 3'b101: cnt_d = 4'd7;
            3'b110, 3'b111: cnt_d = 4'd15;
            default:        cnt_d = 4'd0;
          endcase
        end
        TRANS_SEQ: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            cnt_d = 4'd0;
          end
        end
        default: cnt_d = cnt_q;
      endcase
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Address-phase owner, data-phase owner and lock flag advance only when the bus is ready.
  always_comb begin
    master_d   = master_q;
    owner_d    = owner_q;
    mastlock_d = mastlock_q;
    if (HREADY) begin
      master_d   = gidx_s;
      owner_d    = master_q;
      mastlock_d = HLOCK[gidx_s];
    end else begin
      master_d   = master_q;
    end
  end

  // State registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_q    <= 2'b01;
      master_q   <= 1'b0;
      owner_q    <= 1'b0;
      mastlock_q <= 1'b0;
      cnt_q      <= 4'd0;
      last_q     <= 1'b0;
    end else begin
      grant_q    <= grant_d;
      master_q   <= master_d;
      owner_q    <= owner_d;
      mastlock_q <= mastlock_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
    end
  end

  assign HGRANT    = grant_q;
  assign HMASTER   = master_q;
  assign HMASTLOCK = mastlock_q;

  // Subordinate-facing muxes: address/control by address owner, write data by data owner.
  always_comb begin
    if (master_q) begin
      HADDR  = HADDR_M1;
      HTRANS = HTRANS_M1;
      HWRITE = HWRITE_M1;
      HSIZE  = HSIZE_M1;
      HBURST = HBURST_M1;
    end else begin
      HADDR  = HADDR_M0;
      HTRANS = HTRANS_M0;
      HWRITE = HWRITE_M0;
      HSIZE  = HSIZE_M0;
      HBURST = HBURST_M0;
    end
    if (owner_q) begin
      HWDATA = HWDATA_M1;
    end else begin
      HWDATA = HWDATA_M0;
    end
  end

endmodule
